// File: rtl/manchester_nibble_tx_pkg.sv
// ============================================================================
// Module : manchester_nibble_tx_pkg
// Brief  : Shared line-state encodings and Manchester polarity for the
//          Manchester nibble transmitter and its receive-side counterpart.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package manchester_nibble_tx_pkg;

    // Line state machine encoding, shared with the receive state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_EOF  = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Level driven in the first half of a '1' bit (second half is the inverse)
    localparam logic C_MANCH_ONE_FIRST_HALF = 1'b0;

    // Line level for one half of a Manchester-encoded bit
    function automatic logic manch_half(input logic bit_v, input logic second_half);
        logic first_lvl;
        first_lvl = ~(bit_v ^ C_MANCH_ONE_FIRST_HALF);
        return second_half ? ~first_lvl : first_lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/manch_nibble_shifter.sv
// ============================================================================
// Module : manch_nibble_shifter
// Brief  : 4-bit LSB-first shift register with half-bit phase. Presents the
//          line level of the next half-bit and flags the last half of a nibble.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module manch_nibble_shifter
    import manchester_nibble_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] load_data_i,
    input  logic       advance_i,
    output logic       half_next_o,
    output logic       nibble_end_o
);

    // tick_cnt = {bit index[1:0], half}
    logic [3:0] sr_q;
    logic [3:0] sr_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next shift/phase: shift right once per completed bit
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = load_data_i;
            cnt_d = 3'd0;
        end else if (advance_i) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q[0]) begin
                sr_d = {1'b0, sr_q[3:1]};
            end
        end
    end

    // Shift register and phase counter state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sr_q  <= 4'd0;
            cnt_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // From first half go to second half of same bit; from second half go to next bit
    assign half_next_o  = cnt_q[0] ? manch_half(sr_q[1], 1'b0) : manch_half(sr_q[0], 1'b1);
    assign nibble_end_o = (cnt_q == 3'd7);

endmodule

`default_nettype wire

// File: rtl/manchester_nibble_tx.sv
// ============================================================================
// Module : manchester_nibble_tx
// Brief  : Manchester nibble transmitter. Valid/ready nibble input with a
//          one-entry hold register, LSB-first serialisation on clk2x_en ticks,
//          end-of-frame high hold, inter-frame gap and underrun frame drop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module manchester_nibble_tx
    import manchester_nibble_tx_pkg::*;
#(
    parameter int EOF_HALF_BITS = 4,
    parameter int IFG_HALF_BITS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk2x_en,
    input  logic       tx_enable,
    input  logic       nib_valid,
    input  logic [3:0] nib_data,
    input  logic       nib_last,
    output logic       nib_ready,
    output logic       manch_out,
    output logic       manch_oe,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int              C_MAX_HOLD = (EOF_HALF_BITS > IFG_HALF_BITS) ? EOF_HALF_BITS : IFG_HALF_BITS;
    localparam int              C_CW       = $clog2(C_MAX_HOLD + 1);
    localparam logic [C_CW-1:0] C_EOF_LOAD = C_CW'(EOF_HALF_BITS - 1);
    localparam logic [C_CW-1:0] C_IFG_LOAD = C_CW'(IFG_HALF_BITS - 1);

    tx_state_e       state_q;
    logic [C_CW-1:0] cnt_q;
    logic            manch_out_q;
    logic            manch_oe_q;
    logic            frame_done_q;
    logic            underrun_q;
    logic            aborted_q;
    logic            cur_last_q;

    logic            hold_full_q;
    logic            hold_full_d;
    logic [3:0]      hold_data_q;
    logic            hold_last_q;
    logic            ready_q;
    logic            drop_q;

    logic            half_next_d;
    logic            nibble_end_d;
    logic            start_d;
    logic            reload_d;
    logic            underrun_d;
    logic            advance_d;
    logic            discard_d;
    logic            hold_first_d;

    assign start_d      = clk2x_en && (state_q == ST_IDLE) && hold_full_q && tx_enable && !drop_q;
    assign reload_d     = clk2x_en && (state_q == ST_SEND) && nibble_end_d && !cur_last_q && hold_full_q;
    assign underrun_d   = clk2x_en && (state_q == ST_SEND) && nibble_end_d && !cur_last_q && !hold_full_q;
    assign advance_d    = clk2x_en && (state_q == ST_SEND) && !nibble_end_d;
    assign discard_d    = drop_q && hold_full_q;
    assign hold_first_d = manch_half(hold_data_q[0], 1'b0);

    manch_nibble_shifter u_shifter (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_i       (start_d || reload_d),
        .load_data_i  (hold_data_q),
        .advance_i    (advance_d),
        .half_next_o  (half_next_d),
        .nibble_end_o (nibble_end_d)
    );

    // Hold occupancy: emptied by a shifter load or a drop discard, filled by a handshake
    always_comb begin
        hold_full_d = hold_full_q;
        if (start_d || reload_d || discard_d) begin
            hold_full_d = 1'b0;
        end else if (nib_valid && ready_q) begin
            hold_full_d = 1'b1;
        end
    end

    // Hold register, registered ready and underrun frame-drop tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_data_q <= 4'd0;
            hold_last_q <= 1'b0;
            ready_q     <= 1'b1;
            drop_q      <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            if (nib_valid && ready_q) begin
                hold_data_q <= nib_data;
                hold_last_q <= nib_last;
            end
            if (underrun_d) begin
                drop_q <= 1'b1;
            end else if (discard_d && hold_last_q) begin
                drop_q <= 1'b0;
            end
        end
    end

    // Line state machine with registered line outputs and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            manch_out_q  <= 1'b0;
            manch_oe_q   <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            aborted_q    <= 1'b0;
            cur_last_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            if (clk2x_en) begin
                case (state_q)
                    ST_IDLE: begin
                        manch_oe_q  <= 1'b0;
                        manch_out_q <= 1'b0;
                        if (start_d) begin
                            state_q     <= ST_SEND;
                            manch_oe_q  <= 1'b1;
                            manch_out_q <= hold_first_d;
                            cur_last_q  <= hold_last_q;
                            aborted_q   <= 1'b0;
                        end
                    end
                    ST_SEND: begin
                        if (!nibble_end_d) begin
                            manch_out_q <= half_next_d;
                        end else if (cur_last_q) begin
                            state_q     <= ST_EOF;
                            manch_out_q <= 1'b1;
                            cnt_q       <= C_EOF_LOAD;
                        end else if (hold_full_q) begin
                            manch_out_q <= hold_first_d;
                            cur_last_q  <= hold_last_q;
                        end else begin
                            underrun_q  <= 1'b1;
                            aborted_q   <= 1'b1;
                            state_q     <= ST_EOF;
                            manch_out_q <= 1'b1;
                            cnt_q       <= C_EOF_LOAD;
                        end
                    end
                    ST_EOF: begin
                        if (cnt_q == '0) begin
                            state_q      <= ST_GAP;
                            manch_oe_q   <= 1'b0;
                            manch_out_q  <= 1'b0;
                            cnt_q        <= C_IFG_LOAD;
                            frame_done_q <= ~aborted_q;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign nib_ready  = ready_q;
    assign manch_out  = manch_out_q;
    assign manch_oe   = manch_oe_q;
    assign tx_busy    = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_manchester_nibble_tx.sv
// ============================================================================
// Module : tb_manchester_nibble_tx
// Brief  : Self-checking bench for manchester_nibble_tx. A reference model
//          expands nibble lists into the expected per-tick line sequence.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_manchester_nibble_tx;

    localparam int EOF_N = 4;
    localparam int IFG_N = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk2x_en;
    logic       tx_enable;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       nib_last;
    logic       nib_ready;
    logic       manch_out;
    logic       manch_oe;
    logic       tx_busy;
    logic       frame_done;
    logic       underrun;

    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;
    int   un_cnt = 0;
    logic gate_on;
    logic ph;
    logic rec_oe[$];
    logic rec_out[$];

    manchester_nibble_tx #(.EOF_HALF_BITS(EOF_N), .IFG_HALF_BITS(IFG_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk2x_en   (clk2x_en),
        .tx_enable  (tx_enable),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .nib_last   (nib_last),
        .nib_ready  (nib_ready),
        .manch_out  (manch_out),
        .manch_oe   (manch_oe),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // clk2x_en strobe every second clk, forced low while gated
    initial begin
        forever begin
            @(negedge clk);
            if (gate_on) begin
                ph       = ~ph;
                clk2x_en = ph;
            end else begin
                clk2x_en = 1'b0;
            end
        end
    end

    // Record the line after every tick
    always @(posedge clk) begin
        if (clk2x_en === 1'b1) begin
            #1;
            rec_oe.push_back(manch_oe);
            rec_out.push_back(manch_out);
        end
    end

    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1) fd_cnt++;
        if (underrun === 1'b1) un_cnt++;
    end

    task automatic clear_rec();
        rec_oe.delete();
        rec_out.delete();
        fd_cnt = 0;
        un_cnt = 0;
    endtask

    function automatic int first_oe();
        for (int i = 0; i < rec_oe.size(); i++) begin
            if (rec_oe[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    task automatic push_nib(input logic [3:0] d, input logic l);
        int k;
        @(negedge clk);
        nib_valid = 1'b1;
        nib_data  = d;
        nib_last  = l;
        k = 0;
        while (nib_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 2000) begin
            errors++;
            $display("FAIL push_timeout: nib_ready=%b, required 1", nib_ready);
        end
        @(negedge clk);
        nib_valid = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int k;
        k = 0;
        while (tx_busy !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL %s_start_timeout: tx_busy=%b, required 1", name, tx_busy);
        end
        k = 0;
        while (tx_busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 3000) begin
            errors++;
            $display("FAIL %s_end_timeout: tx_busy=%b, required 0", name, tx_busy);
        end
    endtask

    // Reference model: halves per bit LSB-first, then EOF high, then gap with oe low
    task automatic check_stream(input logic [3:0] nibs[$], input string name);
        logic eo[$];
        logic ex[$];
        logic bv;
        int   i0;
        foreach (nibs[n]) begin
            for (int b = 0; b < 4; b++) begin
                bv = nibs[n][b];
                eo.push_back(1'b1); ex.push_back(~bv);
                eo.push_back(1'b1); ex.push_back(bv);
            end
        end
        for (int i = 0; i < EOF_N; i++) begin eo.push_back(1'b1); ex.push_back(1'b1); end
        for (int i = 0; i < IFG_N; i++) begin eo.push_back(1'b0); ex.push_back(1'b0); end
        i0 = first_oe();
        checks++;
        if (i0 < 0) begin
            errors++;
            $display("FAIL %s_no_oe: oe never 1 in %0d ticks, required a frame", name, rec_oe.size());
            return;
        end
        for (int j = 0; j < eo.size(); j++) begin
            checks++;
            if (i0 + j >= rec_oe.size()) begin
                errors++;
                $display("FAIL %s[%0d]: tick missing, required oe=%b out=%b", name, j, eo[j], ex[j]);
            end else if ({rec_oe[i0+j], rec_out[i0+j]} !== {eo[j], ex[j]}) begin
                errors++;
                $display("FAIL %s[%0d]: got oe=%b out=%b, required oe=%b out=%b",
                         name, j, rec_oe[i0+j], rec_out[i0+j], eo[j], ex[j]);
            end
        end
    endtask

    task automatic check_pulses(input string name, input int fd_exp, input int un_exp);
        checks++;
        if (fd_cnt !== fd_exp) begin
            errors++;
            $display("FAIL %s_frame_done: got %0d pulses, required %0d", name, fd_cnt, fd_exp);
        end
        checks++;
        if (un_cnt !== un_exp) begin
            errors++;
            $display("FAIL %s_underrun: got %0d pulses, required %0d", name, un_cnt, un_exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({manch_oe, manch_out, nib_ready, tx_busy, frame_done, underrun} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_state: got oe=%b out=%b rdy=%b busy=%b fd=%b un=%b, required 0 0 1 0 0 0",
                     manch_oe, manch_out, nib_ready, tx_busy, frame_done, underrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] q[$];
        clear_rec();
        q.push_back(4'hA);
        push_nib(4'hA, 1'b1);
        wait_frame("single");
        check_stream(q, "single");
        check_pulses("single", 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] q[$];
        clear_rec();
        q.push_back(4'h5);
        q.push_back(4'h5);
        push_nib(4'h5, 1'b0);
        push_nib(4'h5, 1'b1);
        wait_frame("b2b");
        check_stream(q, "b2b");
        check_pulses("b2b", 1, 0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            logic [3:0] q[$];
            int n;
            clear_rec();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(4'($urandom_range(0, 15)));
            for (int i = 0; i < n; i++) push_nib(q[i], (i == n - 1));
            wait_frame("rand");
            check_stream(q, "rand");
            check_pulses("rand", 1, 0);
        end
    endtask

    task automatic test_underrun();
        logic [3:0] q[$];
        clear_rec();
        q.push_back(4'h3);
        push_nib(4'h3, 1'b0);
        wait_frame("underrun");
        check_stream(q, "underrun");
        check_pulses("underrun", 0, 1);
        // Remainder of the broken frame is discarded
        clear_rec();
        push_nib(4'h1, 1'b0);
        push_nib(4'h2, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (first_oe() != -1 || tx_busy !== 1'b0 || nib_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop: got first_oe=%0d busy=%b rdy=%b, required -1 0 1", first_oe(), tx_busy, nib_ready);
        end
        clear_rec();
        q.delete();
        q.push_back(4'hF);
        push_nib(4'hF, 1'b1);
        wait_frame("after_drop");
        check_stream(q, "after_drop");
        check_pulses("after_drop", 1, 0);
    endtask

    task automatic test_tx_enable();
        logic [3:0] q[$];
        @(negedge clk);
        tx_enable = 1'b0;
        push_nib(4'h6, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if ({tx_busy, manch_oe, nib_ready} !== 3'b000) begin
            errors++;
            $display("FAIL txen_hold: got busy=%b oe=%b rdy=%b, required 0 0 0", tx_busy, manch_oe, nib_ready);
        end
        clear_rec();
        q.push_back(4'h6);
        tx_enable = 1'b1;
        wait_frame("txen");
        checks++;
        if (rec_oe.size() == 0 || rec_oe[0] !== 1'b1) begin
            errors++;
            $display("FAIL txen_first_tick: got first_oe index=%0d, required 0", first_oe());
        end
        check_stream(q, "txen");
    endtask

    task automatic test_async_reset();
        int k;
        int i0;
        clear_rec();
        push_nib(4'hC, 1'b0);
        push_nib(4'h3, 1'b1);
        k = 0;
        i0 = -1;
        while (k < 200) begin
            @(posedge clk);
            #2;
            i0 = first_oe();
            if (i0 >= 0 && rec_oe.size() >= i0 + 5) break;
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL arst_wait: got %0d ticks recorded, required bit2 reached", rec_oe.size());
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({manch_oe, manch_out, nib_ready, tx_busy} !== 4'b0010) begin
            errors++;
            $display("FAIL arst_immediate: got oe=%b out=%b rdy=%b busy=%b, required 0 0 1 0",
                     manch_oe, manch_out, nib_ready, tx_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_rec();
        repeat (40) @(negedge clk);
        checks++;
        if (first_oe() != -1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_quiet: got first_oe=%0d busy=%b, required -1 0", first_oe(), tx_busy);
        end
    endtask

    task automatic test_gate();
        logic [3:0] q[$];
        logic       v;
        int         bad;
        int         k;
        int         i0;
        clear_rec();
        q.push_back(4'h9);
        push_nib(4'h9, 1'b1);
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            #2;
            i0 = first_oe();
            if (i0 >= 0 && rec_oe.size() >= i0 + 3) break;
            k++;
        end
        gate_on = 1'b0;
        v = manch_out;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (manch_out !== v || manch_oe !== 1'b1) bad++;
        end
        checks++;
        if (k >= 200 || bad != 0) begin
            errors++;
            $display("FAIL gate_hold: got %0d changed clks (wait=%0d), required 0", bad, k);
        end
        gate_on = 1'b1;
        wait_frame("gate");
        check_stream(q, "gate");
        check_pulses("gate", 1, 0);
    endtask

    initial begin
        reset     = 1'b1;
        gate_on   = 1'b1;
        ph        = 1'b0;
        clk2x_en  = 1'b0;
        tx_enable = 1'b1;
        nib_valid = 1'b0;
        nib_data  = 4'h0;
        nib_last  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_frames();
        test_underrun();
        test_tx_enable();
        test_async_reset();
        test_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
